// File: rtl/lsu_load_rsp.sv
// Load response path: alignment/funct3 check, lane select, extend, register.
// Optional I/O wait timeout enabled by defining LSU_IO_TIMEOUT_EN.
module lsu_load_rsp #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ld_req,
  input  logic [31:0] i_lsu_addr,
  input  logic [2:0]  i_funct3,
  input  logic        i_dmem_valid,
  input  logic        i_io_valid,
  input  logic [31:0] i_dmem_rdata,
  input  logic [31:0] i_io_rdata,
  input  logic        i_io_rvalid,
  output logic        o_io_rreq,
  output logic        o_ld_valid,
  output logic [31:0] o_ld_data,
  output logic        o_ld_err,
  output logic        o_busy
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_DMEM = 2'd1;
  localparam logic [1:0] WAIT_IO   = 2'd2;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be 1..255");
  end

  logic [1:0]  state;
  logic [1:0]  a_q;
  logic [2:0]  f3_q;
  logic        bad;
  logic [31:0] src;
  logic [31:0] fmt_data;

`ifdef LSU_IO_TIMEOUT_EN
  logic [7:0] cnt;
  logic       to_hit;
  assign to_hit = (cnt == 8'(TIMEOUT_CYCLES - 1));
`endif

  function automatic logic [31:0] fmt(
    input logic [31:0] d,
    input logic [1:0]  a,
    input logic [2:0]  f
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = d[8*a +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    unique case (1'b1)
      (f == 3'b000): r = {{24{b[7]}}, b};
      (f == 3'b100): r = {24'd0, b};
      (f == 3'b001): r = {{16{h[15]}}, h};
      (f == 3'b101): r = {16'd0, h};
      default:       r = d;
    endcase
    return r;
  endfunction

  // Request validation: illegal funct3, misalignment, or unmapped address.
  always_comb begin
    bad = 1'b0;
    unique case (i_funct3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = i_lsu_addr[0];
      3'b010:         bad = |i_lsu_addr[1:0];
      default:        bad = 1'b1;
    endcase
    if (!(i_dmem_valid || i_io_valid))
      bad = 1'b1;
  end

  assign src      = (state == WAIT_IO) ? i_io_rdata : i_dmem_rdata;
  assign fmt_data = fmt(src, a_q, f3_q);
  assign o_busy    = (state != IDLE);
  assign o_io_rreq = (state == WAIT_IO);

  // Load FSM and registered response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      f3_q       <= '0;
      o_ld_valid <= 1'b0;
      o_ld_data  <= '0;
      o_ld_err   <= 1'b0;
`ifdef LSU_IO_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      o_ld_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_ld_req) begin
            a_q  <= i_lsu_addr[1:0];
            f3_q <= i_funct3;
            if (bad) begin
              o_ld_valid <= 1'b1;
              o_ld_err   <= 1'b1;
              o_ld_data  <= '0;
            end else if (i_dmem_valid) begin
              state <= WAIT_DMEM;
            end else begin
              state <= WAIT_IO;
`ifdef LSU_IO_TIMEOUT_EN
              cnt   <= '0;
`endif
            end
          end
        end
        WAIT_DMEM: begin
          o_ld_valid <= 1'b1;
          o_ld_err   <= 1'b0;
          o_ld_data  <= fmt_data;
          state      <= IDLE;
        end
        WAIT_IO: begin
          if (i_io_rvalid) begin
            o_ld_valid <= 1'b1;
            o_ld_err   <= 1'b0;
            o_ld_data  <= fmt_data;
            state      <= IDLE;
          end
`ifdef LSU_IO_TIMEOUT_EN
          else if (to_hit) begin
            o_ld_valid <= 1'b1;
            o_ld_err   <= 1'b1;
            o_ld_data  <= '0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_load_rsp.sv
// Bench for lsu_load_rsp: directed plan checks plus randomized run
// against a transaction-level reference model.
module tb_lsu_load_rsp;

  localparam int TO = 4;
`ifdef LSU_IO_TIMEOUT_EN
  localparam int IO_WAIT = 3;
`else
  localparam int IO_WAIT = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic [2:0]  f3 = '0;
  logic        dm = 1'b0;
  logic        io = 1'b0;
  logic [31:0] dm_rd = '0;
  logic [31:0] io_rd = '0;
  logic        rvalid = 1'b0;
  logic        rreq;
  logic        valid;
  logic [31:0] data;
  logic        err;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  lsu_load_rsp #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_ld_req(req),
    .i_lsu_addr(addr),
    .i_funct3(f3),
    .i_dmem_valid(dm),
    .i_io_valid(io),
    .i_dmem_rdata(dm_rd),
    .i_io_rdata(io_rd),
    .i_io_rvalid(rvalid),
    .o_io_rreq(rreq),
    .o_ld_valid(valid),
    .o_ld_data(data),
    .o_ld_err(err),
    .o_busy(busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: one outstanding transaction, results by arithmetic.
  function automatic logic [31:0] ref_fmt(input logic [31:0] d,
                                          input int a, input int f);
    logic [31:0] b, h;
    b = (d >> (8 * a)) & 32'hFF;
    h = (d >> (16 * (a / 2))) & 32'hFFFF;
    case (f)
      0: return (b >= 128) ? b - 32'd256 : b;
      4: return b;
      1: return (h >= 32768) ? h - 32'd65536 : h;
      5: return h;
      default: return d;
    endcase
  endfunction

  function automatic bit ref_bad(input int a, input int f,
                                 input bit d, input bit i);
    if (f == 3 || f == 6 || f == 7) return 1;
    if ((f == 1 || f == 5) && (a % 2) != 0) return 1;
    if (f == 2 && a != 0) return 1;
    if (!d && !i) return 1;
    return 0;
  endfunction

  bit          m_busy = 0;
  bit          m_io = 0;
  bit          m_v = 0;
  bit          m_e = 0;
  logic [31:0] m_d = '0;
  int          m_a = 0;
  int          m_f = 0;
  int          m_cnt = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_io = 0; m_v = 0; m_e = 0; m_d = '0;
      m_a = 0; m_f = 0; m_cnt = 0;
    end else begin
      m_v = 0;
      if (!m_busy) begin
        if (req) begin
          if (ref_bad(int'(addr[1:0]), int'(f3), dm, io)) begin
            m_v = 1; m_e = 1; m_d = '0;
          end else begin
            m_busy = 1;
            m_io = !dm;
            m_a = int'(addr[1:0]);
            m_f = int'(f3);
            m_cnt = 0;
          end
        end
      end else if (!m_io) begin
        m_v = 1; m_e = 0; m_d = ref_fmt(dm_rd, m_a, m_f);
        m_busy = 0;
      end else if (rvalid) begin
        m_v = 1; m_e = 0; m_d = ref_fmt(io_rd, m_a, m_f);
        m_busy = 0;
      end
`ifdef LSU_IO_TIMEOUT_EN
      else begin
        m_cnt++;
        if (m_cnt == TO) begin
          m_v = 1; m_e = 1; m_d = '0;
          m_busy = 0;
        end
      end
`endif
    end
  end

  // Compare process: every output against the model each cycle.
  initial forever begin
    @(negedge clk);
    chk("m_valid", valid, m_v);
    chk("m_busy", busy, m_busy);
    chk("m_rreq", rreq, m_busy && m_io);
    chk("m_err", err, m_e);
    chk("m_data", data, m_d);
  end

  task automatic ld_dmem(input logic [31:0] ad, input logic [2:0] f,
                         input logic [31:0] rd, input logic [31:0] ex);
    req = 1; addr = ad; f3 = f; dm = 1; io = 0; dm_rd = rd; rvalid = 0;
    @(negedge clk);
    chk("dm_busy", busy, 1);
    chk("dm_early", valid, 0);
    req = 0;
    @(negedge clk);
    chk("dm_valid", valid, 1);
    chk("dm_data", data, ex);
    chk("dm_err", err, 0);
    chk("dm_idle", busy, 0);
  endtask

  task automatic ld_err(input logic [31:0] ad, input logic [2:0] f,
                        input logic d, input logic i);
    req = 1; addr = ad; f3 = f; dm = d; io = i;
    @(negedge clk);
    chk("er_valid", valid, 1);
    chk("er_err", err, 1);
    chk("er_data", data, 0);
    chk("er_busy", busy, 0);
    chk("er_rreq", rreq, 0);
    req = 0;
    @(negedge clk);
    chk("er_pulse", valid, 0);
  endtask

  initial begin
    #1 rst_n = 0;
    #2;
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rreq", rreq, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    ld_dmem(32'h0000_0103, 3'b000, 32'h80FF_1234, 32'hFFFF_FF80);
    ld_dmem(32'h0000_0002, 3'b101, 32'h9ABC_5678, 32'h0000_9ABC);
    ld_dmem(32'h0000_0002, 3'b001, 32'h9ABC_5678, 32'hFFFF_9ABC);
    ld_dmem(32'h0000_0004, 3'b010, 32'h9ABC_5678, 32'h9ABC_5678);

    ld_err(32'h0000_0006, 3'b010, 1, 0);
    ld_err(32'h0000_0000, 3'b011, 1, 0);
    ld_err(32'h2000_0000, 3'b010, 0, 0);

    req = 1; addr = 32'h1001_0000; f3 = 3'b010; dm = 0; io = 1;
    for (int k = 1; k <= IO_WAIT; k++) begin
      @(negedge clk);
      req = 0;
      chk("io_rreq", rreq, 1);
      chk("io_wait", valid, 0);
    end
    rvalid = 1; io_rd = 32'h0000_00A5;
    @(negedge clk);
    chk("io_valid", valid, 1);
    chk("io_data", data, 32'h0000_00A5);
    chk("io_drop", rreq, 0);
    @(negedge clk);
    chk("io_stray", valid, 0);
    rvalid = 0;

    req = 1; addr = 32'h0; f3 = 3'b010; dm = 1; io = 0;
    dm_rd = 32'h1111_2222;
    @(negedge clk);
    chk("b2b_busy", busy, 1);
    @(negedge clk);
    chk("b2b_v1", valid, 1);
    chk("b2b_d1", data, 32'h1111_2222);
    dm_rd = 32'h3333_4444;
    @(negedge clk);
    chk("b2b_gap", valid, 0);
    chk("b2b_busy2", busy, 1);
    req = 0;
    @(negedge clk);
    chk("b2b_v2", valid, 1);
    chk("b2b_d2", data, 32'h3333_4444);

`ifdef LSU_IO_TIMEOUT_EN
    req = 1; addr = 32'h1001_0000; f3 = 3'b010; dm = 0; io = 1;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      req = 0;
      chk("to_rreq", rreq, 1);
    end
    @(negedge clk);
    chk("to_valid", valid, 1);
    chk("to_err", err, 1);
    chk("to_data", data, 0);
    chk("to_rreq_off", rreq, 0);
`endif

    req = 1; addr = 32'h1001_0004; f3 = 3'b010; dm = 0; io = 1;
    @(negedge clk);
    req = 0;
    chk("ra_rreq", rreq, 1);
    #2 rst_n = 0;
    #1;
    chk("ra_busy", busy, 0);
    chk("ra_rreq0", rreq, 0);
    chk("ra_valid", valid, 0);
    chk("ra_data", data, 0);
    chk("ra_err", err, 0);
    rvalid = 1;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("ra_ignore", valid, 0);
    rvalid = 0;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1;
      req = ($urandom_range(0, 1) == 1);
      addr = $urandom;
      f3 = 3'($urandom_range(0, 7));
      dm = ($urandom_range(0, 2) == 0);
      io = ($urandom_range(0, 2) != 0);
      dm_rd = $urandom;
      io_rd = $urandom;
      rvalid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 399) == 0) #2 rst_n = 0;
    end
    @(negedge clk);
    rst_n = 1;
    req = 0;
    rvalid = 0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
